alu_serie: RTL and testbench

//  Parametrised bit-serial ALU, successor to the 1-bit combinational slice.
//  - Processes WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder/subtractor slice with a registered carry/borrow.
//  - Uses a start/busy/done handshake.
//  - Adds logic ops (AND/OR/XOR), zero and signed-overflow flags, and an invalid-op flag.
//  - Sits between the register file and the result bus in the serial datapath.

---
 rtl/alu_serie.sv | 143 ++++++++++++++
 tb/tb_alu_serie.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_serie.sv
// Bit-serial ALU: WIDTH-bit operands are processed LSB-first through one
// full-adder/subtractor slice, with a start/busy/done handshake.
module alu_serie #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             CB_in,
  input  logic [2:0]       code_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CB_out,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101
  } op_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] shift_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, op_valid, arith_in, arith_q, last;
  logic             bit_r, carry_next;
  logic [WIDTH-1:0] result_final;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign op_valid = (code_op >= 3'd1) && (code_op <= 3'd5);
  assign arith_in = (code_op == OP_ADD) || (code_op == OP_SUB);
  assign arith_q  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last     = (cnt_q == CW'(WIDTH - 1));

  // One bit of the selected operation on the current LSBs of the operand shifters.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    bit_r      = 1'b0;
    carry_next = 1'b0;
    case (op_q)
      OP_ADD: begin
        bit_r      = a_q[0] ^ b_q[0] ^ carry_q;
        carry_next = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
      end
      OP_SUB: begin
        bit_r      = a_q[0] ^ b_q[0] ^ carry_q;
        carry_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & carry_q);
      end
      OP_AND:  bit_r = a_q[0] & b_q[0];
      OP_OR:   bit_r = a_q[0] | b_q[0];
      OP_XOR:  bit_r = a_q[0] ^ b_q[0];
      default: ;
    endcase
  end

  // The new bit enters from the MSB side, so after WIDTH shifts it is in order.
  assign result_final = {bit_r, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = op_valid ? S_RUN : S_DONE;
        else       state_next = S_IDLE;
      end
      S_RUN:   if (last) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is reset too, so an aborted operation leaves no residue.
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      Result  <= '0;
      CB_out  <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else if (accept) begin
      if (op_valid) begin
        a_q     <= In1;
        b_q     <= In2;
        op_q    <= code_op;
        carry_q <= arith_in ? CB_in : 1'b0;
        cnt_q   <= '0;
      end else begin
        Result <= '0;
        CB_out <= 1'b0;
        zero   <= 1'b1;
        ovf    <= 1'b0;
        err    <= 1'b1;
      end
    end else if (state == S_RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= carry_next;
      shift_q <= result_final[WIDTH-1:1];
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        // carry_q here is the carry into the MSB, carry_next the carry out of it.
        Result <= result_final;
        CB_out <= arith_q ? carry_next : 1'b0;
        ovf    <= arith_q ? (carry_q ^ carry_next) : 1'b0;
        zero   <= (result_final == '0);
        err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_serie.sv
// Directed bench for alu_serie: WIDTH=8 instance for the main cases and a
// WIDTH=16 instance for the wide carry-out case.
module tb_alu_serie;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in1 = '0, in2 = '0;
  logic       cb_in = 1'b0;
  logic [2:0] code_op = '0;
  logic       busy, done, cb_out, zero, ovf, err;
  logic [7:0] result;

  logic        start16 = 1'b0;
  logic [15:0] in1_16 = '0, in2_16 = '0;
  logic        cb_in16 = 1'b0;
  logic [2:0]  code_op16 = '0;
  logic        busy16, done16, cb_out16, zero16, ovf16, err16;
  logic [15:0] result16;

  int checks = 0;
  int failures = 0;
  int lat;

  always #5 clk = ~clk;

  alu_serie #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .In1(in1), .In2(in2),
    .CB_in(cb_in), .code_op(code_op), .busy(busy), .done(done),
    .Result(result), .CB_out(cb_out), .zero(zero), .ovf(ovf), .err(err)
  );

  alu_serie #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .In1(in1_16), .In2(in2_16),
    .CB_in(cb_in16), .code_op(code_op16), .busy(busy16), .done(done16),
    .Result(result16), .CB_out(cb_out16), .zero(zero16), .ovf(ovf16), .err(err16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts an op from a negedge; returns the number of rising edges up to the
  // one after which done is seen (the accepting edge counts as 1).
  task automatic launch(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cbin, input bit disturb, output int n);
    code_op = op; in1 = a; in2 = b; cb_in = cbin; start = 1'b1;
    @(posedge clk); n = 1;
    @(negedge clk); start = 1'b0;
    while (!done && n < 40) begin
      if (disturb && n == 3) begin
        start = 1'b1; in1 = 8'hFF; in2 = 8'hFF; code_op = 3'b010; cb_in = 1'b1;
      end
      @(posedge clk); n++;
      @(negedge clk); start = 1'b0;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cbin, output int n);
    @(negedge clk);
    launch(op, a, b, cbin, 1'b0, n);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_outs", {busy, done, result, cb_out, zero, ovf, err}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {busy, done, result, cb_out, zero, ovf, err}, '0);

    // 1: FF + 01 wraps to zero with carry out
    do_op(3'b001, 8'hFF, 8'h01, 1'b0, lat);
    check("add_lat", lat, 9);
    check("add_res", {result, cb_out, zero, ovf, err}, {8'h00, 4'b1100});
    @(negedge clk);
    check("done_pulse", done, 1'b0);

    // 2: subtraction with borrow, then signed overflow
    do_op(3'b010, 8'h05, 8'h07, 1'b0, lat);
    check("sub_borrow", {result, cb_out, zero, ovf, err}, {8'hFE, 4'b1000});
    do_op(3'b010, 8'h80, 8'h01, 1'b0, lat);
    check("sub_ovf", {result, cb_out, zero, ovf, err}, {8'h7F, 4'b0010});
    do_op(3'b001, 8'h7F, 8'h00, 1'b1, lat);
    check("add_cin_ovf", {result, cb_out, zero, ovf, err}, {8'h80, 4'b0010});

    // 3: logic ops ignore CB_in
    do_op(3'b011, 8'hA5, 8'h3C, 1'b1, lat);
    check("and", {result, cb_out, zero, ovf, err}, {8'h24, 4'b0000});
    do_op(3'b100, 8'hA5, 8'h3C, 1'b1, lat);
    check("or", {result, cb_out, zero, ovf, err}, {8'hBD, 4'b0000});
    do_op(3'b101, 8'hA5, 8'h3C, 1'b1, lat);
    check("xor", {result, cb_out, zero, ovf, err}, {8'h99, 4'b0000});
    check("logic_lat", lat, 9);

    // 4: invalid op, then a valid add clears err
    do_op(3'b111, 8'h12, 8'h34, 1'b1, lat);
    check("inv_lat", lat, 1);
    check("inv_res", {result, cb_out, zero, ovf, err}, {8'h00, 4'b0101});
    do_op(3'b001, 8'h10, 8'h20, 1'b1, lat);
    check("err_clear", {result, cb_out, zero, ovf, err}, {8'h31, 4'b0000});

    // 5: start mid-RUN ignored; back-to-back from DONE
    @(negedge clk);
    launch(3'b001, 8'h12, 8'h34, 1'b0, 1'b1, lat);
    check("ignore_lat", lat, 9);
    check("ignore_res", {result, cb_out, zero, ovf, err}, {8'h46, 4'b0000});
    launch(3'b010, 8'h09, 8'h03, 1'b0, 1'b0, lat);
    check("b2b_lat", lat, 9);
    check("b2b_res", {result, cb_out, zero, ovf, err}, {8'h06, 4'b0000});

    // 6: async reset in the middle of RUN
    @(negedge clk);
    code_op = 3'b001; in1 = 8'h55; in2 = 8'h0F; cb_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("run_busy", busy, 1'b1);
    check("run_hold", result, 8'h06);
    #2 rst_n = 1'b0;
    #1 check("mid_reset", {busy, done, result, cb_out, zero, ovf, err}, '0);
    @(negedge clk); rst_n = 1'b1;
    do_op(3'b001, 8'h55, 8'h0F, 1'b0, lat);
    check("post_reset_lat", lat, 9);
    check("post_reset_res", {result, cb_out, zero, ovf, err}, {8'h64, 4'b0000});

    // WIDTH=16: FFFF + 0001
    @(negedge clk);
    code_op16 = 3'b001; in1_16 = 16'hFFFF; in2_16 = 16'h0001; cb_in16 = 1'b0; start16 = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); start16 = 1'b0;
    while (!done16 && lat < 60) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check("w16_lat", lat, 17);
    check("w16_res", {result16, cb_out16, zero16, ovf16, err16}, {16'h0000, 4'b1100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
